// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: fetch FSM states, segment bases and exception codes.
// Imported by the fetch stage and its address-mapping helper.
package cpu_defs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DISCARD
    } fetch_state_t;

    localparam logic [31:0] KSEG0_BASE = 32'h8000_0000;
    localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
    localparam logic [4:0]  EXC_ADEL   = 5'h04;

endpackage

// File: rtl/fetch_addr_map.sv
// Virtual-to-physical map for kseg0/kseg1 (both live under top bits 2'b10).
// Ports: addr (virtual, in), phys (physical, out). Purely combinational.
module fetch_addr_map
    import cpu_defs_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter bit KSEG_MAP = 1'b1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] phys
);

    // kseg0 and kseg1 share top bits 2'b10; clearing the top three bits
    // folds both onto the low 512 MB of physical space.
    always_comb begin
        phys = addr;
        if (KSEG_MAP && (addr[ADDR_W-1 -: 2] == KSEG0_BASE[31:30])) begin
            phys[ADDR_W-1 -: 3] = 3'b000;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: issues one instruction read per PC, delivers {inst, pc, adel} to IF/ID.
// Ports: clk/rst, pc_i/pc_en_o (PC reg), inst_* (SRAM-like bus), flush_i, stall_i, inst_valid_o/inst_o/inst_pc_o/adel_o (IF/ID).
module inst_fetch
    import cpu_defs_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter bit KSEG_MAP = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_en_o,
    output logic              inst_req_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic              inst_addr_ok_i,
    input  logic              inst_data_ok_i,
    input  logic [DATA_W-1:0] inst_rdata_i,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              adel_o
);

    fetch_state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] ipc_q;
    logic [ADDR_W-1:0] phys;
    logic [DATA_W-1:0] inst_q;
    logic              adel_q;
    logic              flush_q;
    logic              flush_nxt;
    logic              start;
    logic              load_req;
    logic              load_adel;
    logic              capture;
    logic              misaligned;

    fetch_addr_map #(
        .ADDR_W   (ADDR_W),
        .KSEG_MAP (KSEG_MAP)
    ) u_map (
        .addr (pc_i),
        .phys (phys)
    );

    assign misaligned = |pc_i[1:0];

    always_comb begin
        state_nxt = state;
        flush_nxt = flush_q;
        pc_en_o   = 1'b0;
        start     = 1'b0;
        load_req  = 1'b0;
        load_adel = 1'b0;
        capture   = 1'b0;

        unique case (state)
            IDLE: begin
                if (!flush_i) start = 1'b1;
            end
            REQ: begin
                // A request cannot be withdrawn; a flush seen while waiting
                // for addr_ok is remembered so the reply gets dropped.
                if (flush_i) flush_nxt = 1'b1;
                if (inst_addr_ok_i) begin
                    pc_en_o   = 1'b1;
                    flush_nxt = 1'b0;
                    if (flush_i || flush_q) begin
                        state_nxt = inst_data_ok_i ? IDLE : DISCARD;
                    end else if (inst_data_ok_i) begin
                        capture   = 1'b1;
                        state_nxt = HOLD;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (flush_i) begin
                    state_nxt = inst_data_ok_i ? IDLE : DISCARD;
                end else if (inst_data_ok_i) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    state_nxt = IDLE;
                end else if (!stall_i) begin
                    state_nxt = IDLE;
                    start     = 1'b1;
                end
            end
            DISCARD: begin
                if (inst_data_ok_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // New fetch: misaligned PCs never reach the bus.
        if (start) begin
            if (misaligned) begin
                load_adel = 1'b1;
                pc_en_o   = 1'b1;
                state_nxt = HOLD;
            end else begin
                load_req  = 1'b1;
                state_nxt = REQ;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            flush_q <= 1'b0;
            addr_q  <= '0;
            pc_q    <= '0;
            inst_q  <= '0;
            ipc_q   <= '0;
            adel_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            flush_q <= flush_nxt;
            if (load_req) begin
                pc_q   <= pc_i;
                addr_q <= phys;
            end
            if (capture) begin
                inst_q <= inst_rdata_i;
                ipc_q  <= pc_q;
                adel_q <= 1'b0;
            end
            if (load_adel) begin
                inst_q <= '0;
                ipc_q  <= pc_i;
                adel_q <= 1'b1;
            end
        end
    end

    assign inst_req_o   = (state == REQ);
    assign inst_addr_o  = addr_q;
    assign inst_valid_o = (state == HOLD);
    assign inst_o       = inst_q;
    assign inst_pc_o    = ipc_q;
    assign adel_o       = adel_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed table-driven bench for inst_fetch, plus reset and KSEG_MAP=0 sequences.
// Drives inputs just after negedge, compares outputs 1 time unit later.
module tb_inst_fetch;

    typedef struct packed {
        logic [31:0] pc;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        flush;
        logic        stall;
    } in_t;

    typedef struct packed {
        logic        pc_en;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] inst;
        logic [31:0] ipc;
        logic        adel;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        aok = 1'b0;
    logic        dok = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;

    logic        pc_en, req, valid, adel;
    logic [31:0] addr, inst, ipc;
    logic        pc_en0, req0, valid0, adel0;
    logic [31:0] addr0, inst0, ipc0;

    int errors = 0;
    int checks = 0;

    vec_t tbl[$];

    always #5 clk = ~clk;

    inst_fetch #(.KSEG_MAP(1'b1)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_i           (pc),
        .pc_en_o        (pc_en),
        .inst_req_o     (req),
        .inst_addr_o    (addr),
        .inst_addr_ok_i (aok),
        .inst_data_ok_i (dok),
        .inst_rdata_i   (rdata),
        .flush_i        (flush),
        .stall_i        (stall),
        .inst_valid_o   (valid),
        .inst_o         (inst),
        .inst_pc_o      (ipc),
        .adel_o         (adel)
    );

    inst_fetch #(.KSEG_MAP(1'b0)) dut0 (
        .clk            (clk),
        .rst            (rst),
        .pc_i           (pc),
        .pc_en_o        (pc_en0),
        .inst_req_o     (req0),
        .inst_addr_o    (addr0),
        .inst_addr_ok_i (aok),
        .inst_data_ok_i (dok),
        .inst_rdata_i   (rdata),
        .flush_i        (flush),
        .stall_i        (stall),
        .inst_valid_o   (valid0),
        .inst_o         (inst0),
        .inst_pc_o      (ipc0),
        .adel_o         (adel0)
    );

    function automatic vec_t mk(
        input logic [31:0] p, input logic a, input logic d,
        input logic [31:0] rd, input logic f, input logic s,
        input logic pe, input logic rq, input logic [31:0] ad,
        input logic vl, input logic [31:0] in, input logic [31:0] ip,
        input logic ae
    );
        vec_t v;
        v.i = '{pc: p, aok: a, dok: d, rdata: rd, flush: f, stall: s};
        v.o = '{pc_en: pe, req: rq, addr: ad, valid: vl,
                inst: in, ipc: ip, adel: ae};
        return v;
    endfunction

    function automatic out_t cur();
        return '{pc_en: pc_en, req: req, addr: addr, valid: valid,
                 inst: inst, ipc: ipc, adel: adel};
    endfunction

    function automatic out_t cur0();
        return '{pc_en: pc_en0, req: req0, addr: addr0, valid: valid0,
                 inst: inst0, ipc: ipc0, adel: adel0};
    endfunction

    task automatic apply(input in_t v);
        pc    = v.pc;
        aok   = v.aok;
        dok   = v.dok;
        rdata = v.rdata;
        flush = v.flush;
        stall = v.stall;
    endtask

    task automatic chk(input string name, input out_t got, input out_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got pc_en=%b req=%b addr=%h valid=%b inst=%h pc=%h adel=%b required pc_en=%b req=%b addr=%h valid=%b inst=%h pc=%h adel=%b",
                     name, got.pc_en, got.req, got.addr, got.valid, got.inst,
                     got.ipc, got.adel, exp.pc_en, exp.req, exp.addr,
                     exp.valid, exp.inst, exp.ipc, exp.adel);
        end
    endtask

    task automatic chk_bit(input string name, input logic [32:0] got,
                           input logic [32:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    localparam logic [31:0] P  = 32'hBFC0_0000;
    localparam logic [31:0] D1 = 32'h2408_0001;
    localparam logic [31:0] D2 = 32'h3C01_0001;
    localparam logic [31:0] A0 = 32'h1FC0_0000;
    localparam logic [31:0] A1 = 32'h1FC0_0004;
    localparam logic [31:0] A2 = 32'h1FC0_0008;
    localparam logic [31:0] AN = 32'h0000_1000;

    initial begin
        out_t z;
        z = '0;

        // Fetch from reset vector; addr_ok at once, data one cycle later.
        tbl.push_back(mk(P,    0,0,0,         0,0, 0,0,'0,0,'0,'0,0));
        tbl.push_back(mk(P,    1,0,0,         0,0, 1,1,A0,0,'0,'0,0));
        tbl.push_back(mk(P+4,  0,1,D1,        0,0, 0,0,A0,0,'0,'0,0));
        // Decode stalls three cycles in HOLD, then consumes.
        tbl.push_back(mk(P+4,  0,0,0,         0,1, 0,0,A0,1,D1,P,0));
        tbl.push_back(mk(P+4,  0,0,0,         0,1, 0,0,A0,1,D1,P,0));
        tbl.push_back(mk(P+4,  0,0,0,         0,1, 0,0,A0,1,D1,P,0));
        tbl.push_back(mk(P+4,  0,0,0,         0,0, 0,0,A0,1,D1,P,0));
        // Next fetch: addr_ok late, then same-cycle addr_ok + data_ok.
        tbl.push_back(mk(P+4,  0,0,0,         0,0, 0,1,A1,0,D1,P,0));
        tbl.push_back(mk(P+4,  1,1,D2,        0,0, 1,1,A1,0,D1,P,0));
        tbl.push_back(mk(P+8,  0,0,0,         0,1, 0,0,A1,1,D2,P+4,0));
        tbl.push_back(mk(P+8,  0,0,0,         0,0, 0,0,A1,1,D2,P+4,0));
        // Flush in WAIT; stale data arrives two cycles later.
        tbl.push_back(mk(P+8,  1,0,0,         0,0, 1,1,A2,0,D2,P+4,0));
        tbl.push_back(mk(P+12, 0,0,0,         1,0, 0,0,A2,0,D2,P+4,0));
        tbl.push_back(mk(32'h8000_1000, 0,0,0,0,0, 0,0,A2,0,D2,P+4,0));
        tbl.push_back(mk(32'h8000_1000, 0,1,32'hDEAD_BEEF,0,0, 0,0,A2,0,D2,P+4,0));
        tbl.push_back(mk(32'h8000_1000, 0,0,0,0,0, 0,0,A2,0,D2,P+4,0));
        // Flush in REQ; addr_ok three cycles later, reply dropped.
        tbl.push_back(mk(32'h8000_1000, 0,0,0,1,0, 0,1,AN,0,D2,P+4,0));
        tbl.push_back(mk(32'h8000_1000, 0,0,0,0,0, 0,1,AN,0,D2,P+4,0));
        tbl.push_back(mk(32'h8000_1000, 0,0,0,0,0, 0,1,AN,0,D2,P+4,0));
        tbl.push_back(mk(32'h8000_1000, 1,0,0,0,0, 1,1,AN,0,D2,P+4,0));
        tbl.push_back(mk(32'h8000_1004, 0,1,32'h1111_1111,0,0, 0,0,AN,0,D2,P+4,0));
        // Misaligned PC: AdEL without bus access.
        tbl.push_back(mk(32'h8000_0002, 0,0,0,0,0, 1,0,AN,0,D2,P+4,0));
        tbl.push_back(mk(32'h8000_0006, 0,0,0,0,1, 0,0,AN,1,'0,32'h8000_0002,1));
        // Flush and stall together in HOLD: flush wins.
        tbl.push_back(mk(32'h8000_0006, 0,0,0,1,1, 0,0,AN,1,'0,32'h8000_0002,1));
        tbl.push_back(mk(32'h8000_0010, 0,0,0,0,0, 0,0,AN,0,'0,32'h8000_0002,1));

        pc = P;
        @(negedge clk);
        #1;
        chk("reset", cur(), z);
        rst = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k].i);
            #1;
            chk($sformatf("vec%0d", k), cur(), tbl[k].o);
            @(negedge clk);
        end

        // Enter WAIT, then assert reset mid-transaction.
        apply(mk(32'h8000_0010,1,0,0,0,0, 0,0,'0,0,'0,'0,0).i);
        #1;
        chk("req_kseg0", cur(),
            '{pc_en: 1'b1, req: 1'b1, addr: 32'h0000_0010, valid: 1'b0,
              inst: 32'h0, ipc: 32'h8000_0002, adel: 1'b1});
        @(negedge clk);
        aok = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst_mid_wait", cur(), z);
        chk("rst_mid_wait_nomap", cur0(), z);
        @(negedge clk);
        pc  = P + 4;
        rst = 1'b1;
        #1;
        chk("post_rst_idle", cur(), z);
        @(negedge clk);
        #1;
        chk_bit("map_on_addr", {req, addr}, {1'b1, A1});
        chk_bit("map_off_addr", {req0, addr0}, {1'b1, P + 32'd4});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
